// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two valid/ready requesters.
// Define RF_INIT_SWEEP_EN to add a post-reset sweep that writes boot values to x1..x31.
module rf_write_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic          busy,
    output logic          grant
);

    logic          rr_q, rr_d;
    logic          we3_q, we3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          grant_q, grant_d;
    logic          sel;
    logic          acc;

`ifdef RF_INIT_SWEEP_EN
    typedef enum logic {INIT, ARB} state_e;
    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    assign busy = (state_q == INIT);
`else
    assign busy = 1'b0;
`endif

    // sel is the requester index that would win this cycle; rr_q=1 prefers req1
    always_comb begin
        sel        = req1_valid && (!req0_valid || rr_q);
        req0_ready = !busy && req0_valid && !sel;
        req1_ready = !busy && req1_valid && sel;
        acc        = req0_ready || req1_ready;
    end

    always_comb begin
        rr_d    = rr_q;
        we3_d   = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        grant_d = grant_q;
`ifdef RF_INIT_SWEEP_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            we3_d = 1'b1;
            wa3_d = AW'(cnt_q);
            if (cnt_q == 5'd5)
                wd3_d = DW'(32'd6);
            else if (cnt_q == 5'd9)
                wd3_d = DW'(32'h2004);
            else
                wd3_d = '0;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
                state_d = ARB;
        end else
`endif
        if (acc) begin
            wa3_d   = sel ? req1_addr : req0_addr;
            wd3_d   = sel ? req1_data : req0_data;
            // x0 writes are consumed but never reach the register file
            we3_d   = (wa3_d != '0);
            grant_d = sel;
            rr_d    = !sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q    <= 1'b0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            grant_q <= 1'b0;
`ifdef RF_INIT_SWEEP_EN
            state_q <= INIT;
            cnt_q   <= 5'd1;
`endif
        end else begin
            rr_q    <= rr_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            grant_q <= grant_d;
`ifdef RF_INIT_SWEEP_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a transaction-level model.
module tb_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          we3, busy, grant;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;

    int n_tests = 0;
    int n_fail  = 0;

    // model: the register-write the port should be presenting, and who won last
    int          last_winner;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_grant;

    rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        last_winner = 1;  // so req0 is preferred first
        m_we = 0; m_wa = 0; m_wd = 0; m_grant = 0;
    endtask

    // reset is asserted while a request is pending, which must not get through
    task automatic do_reset();
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hBAD;
        req1_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_we3", {31'd0, we3}, 0);
        chk("rst_wa3", {27'd0, wa3}, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_grant", {31'd0, grant}, 0);
`ifdef RF_INIT_SWEEP_EN
        chk("rst_busy", {31'd0, busy}, 1);
`else
        chk("rst_busy", {31'd0, busy}, 0);
`endif
        req0_valid = 1'b0;
        rst = 1'b1;
    endtask

    // one arbitration cycle; caller is positioned just after a rising edge
    task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                        output bit acc0, output bit acc1);
        int winner;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        if (v0 && v1) winner = 1 - last_winner;
        else if (v0)  winner = 0;
        else if (v1)  winner = 1;
        else          winner = -1;
        acc0 = (winner == 0);
        acc1 = (winner == 1);
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, acc0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, acc1});
        if (winner >= 0) begin
            last_winner = winner;
            m_grant = winner;
            m_wa = (winner == 1) ? a1 : a0;
            m_wd = (winner == 1) ? d1 : d0;
            m_we = (m_wa != 0);
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
        chk("we3", {31'd0, we3}, {31'd0, m_we});
        chk("wa3", {27'd0, wa3}, {27'd0, m_wa});
        chk("wd3", wd3, m_wd);
        chk("grant", {31'd0, grant}, m_grant);
        chk("busy", {31'd0, busy}, 0);
    endtask

`ifdef RF_INIT_SWEEP_EN
    task automatic sweep(input bit with_req, input int last);
        logic [31:0] exp_wd;
        req0_valid = with_req; req0_addr = 5'd2; req0_data = 32'h77;
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #1;
            exp_wd = (i == 5) ? 32'd6 : (i == 9) ? 32'h2004 : 32'd0;
            chk("sweep_we3", {31'd0, we3}, 1);
            chk("sweep_wa3", {27'd0, wa3}, i);
            chk("sweep_wd3", wd3, exp_wd);
            chk("sweep_busy", {31'd0, busy}, (i < 31) ? 1 : 0);
            if (with_req && i < 31) chk("sweep_ready0", {31'd0, req0_ready}, 0);
            if (i == 30) req0_valid = 1'b0;
        end
        req0_valid = 1'b0;
    endtask
`endif

    initial begin
        bit k0, k1, p0, p1;
        logic [4:0]  ra0, ra1;
        logic [31:0] rd0, rd1;

        do_reset();
`ifdef RF_INIT_SWEEP_EN
        sweep(1'b0, 31);
`endif
        // first request right after reset is accepted at once
        step(1, 5'd3, 32'hDEAD, 0, 5'd0, 32'd0, k0, k1);
        chk("first_wd3", wd3, 32'hDEAD);

        // both continuously valid: grants must alternate, loser holds its request
        ra0 = 5'd10; rd0 = 32'hA000; ra1 = 5'd20; rd1 = 32'hB000;
        for (int i = 0; i < 6; i++) begin
            step(1, ra0, rd0, 1, ra1, rd1, k0, k1);
            chk("alt_one_winner", {31'd0, k0 ^ k1}, 1);
            if (k0) begin ra0 = ra0 + 5'd1; rd0 = rd0 + 32'd1; end
            if (k1) begin ra1 = ra1 + 5'd1; rd1 = rd1 + 32'd1; end
        end

        // write to x0 is consumed without a write enable
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'h55, k0, k1);
        chk("x0_we3", {31'd0, we3}, 0);
        chk("x0_wd3", wd3, 32'h55);
        chk("x0_grant", {31'd0, grant}, 1);

        // req1 wins a collision on x7, req0 holds and writes last
        step(1, 5'd5, 32'h1111, 0, 5'd0, 32'd0, k0, k1);
        step(1, 5'd7, 32'hA7, 1, 5'd7, 32'hB7, k0, k1);
        chk("x7_first", wd3, 32'hB7);
        step(1, 5'd7, 32'hA7, 0, 5'd0, 32'd0, k0, k1);
        chk("x7_last_wa3", {27'd0, wa3}, 7);
        chk("x7_last_wd3", wd3, 32'hA7);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, k0, k1);
        chk("idle_hold_wd3", wd3, 32'hA7);

        do_reset();
`ifdef RF_INIT_SWEEP_EN
        sweep(1'b0, 12);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_we3", {31'd0, we3}, 0);
        chk("midrst_wa3", {27'd0, wa3}, 0);
        rst = 1'b1;
        model_reset();
        sweep(1'b1, 31);
`endif

        p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
        for (int c = 0; c < 300; c++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; ra0 = 5'($urandom_range(0, 31)); rd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; ra1 = 5'($urandom_range(0, 31)); rd1 = $urandom;
            end
            step(p0, ra0, rd0, p1, ra1, rd1, k0, k1);
            if (k0) p0 = 0;
            if (k1) p1 = 0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (we3/wa3/wd3) between two write requesters: the core writeback path (req0) and an auxiliary writer such as a debug or load unit (req1). Requesters use a valid/ready handshake, and a round-robin arbiter picks one of them per cycle. The chosen write is issued through registered outputs that drive the register file directly. After reset, an optional init sequencer sweeps x1..x31 to their boot values before any requester is served.

## Interface
- DW, 32, data width of wd3 and of the request data.
- AW, 5, register address width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- req0_valid  in  1  core writeback request.
- req0_addr  in  AW  destination register.
- req0_data  in  DW  write data.
- req0_ready  out  1  req0 accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready  as for req0, auxiliary requester.
- we3  out  1  register-file write enable (registered).
- wa3  out  AW  register-file write address (registered).
- wd3  out  DW  register-file write data (registered).
- busy  out  1  init sweep in progress; requests are not served.
- grant  out  1  index of the most recently accepted requester (registered).

## Operation
- States: INIT (only when RF_INIT_SWEEP_EN is defined) and ARB. Reset enters INIT, or ARB when the macro is undefined.
- INIT:
  - 5-bit counter cnt starts at 1 and issues one write per cycle: wa3=cnt, we3=1.
  - wd3 = 32'd6 for cnt=5, 32'h2004 for cnt=9, 0 otherwise.
  - The edge that issues cnt=31 moves the state to ARB.
  - busy = (state==INIT). Both readies are forced low.
- ARB:
  - Round-robin pointer rr; 0 means req0 is preferred.
  - Only req0 valid: grant req0. Only req1 valid: grant req1. Both valid: grant req rr.
  - After an accept by requester k, rr = ~k. rr holds when nothing is accepted.
  - reqK_ready is combinational: high only for the granted requester, in the same cycle as its valid.
  - Accept = valid && ready.
- Requester rules: addr and data must be held stable while valid is high and ready is low. Valid must not be withdrawn before ready.
- Output register on each edge:
  - Accept occurs: wa3/wd3 load the accepted addr/data; we3 = (addr != 0); grant = k.
  - No accept: we3=0; wa3, wd3 and grant hold.
  - Writes to x0 are consumed (ready asserts) but never enable we3.
- No accept may occur while busy.

## Timing
- Reset values: we3=0, wa3=0, wd3=0, grant=0, rr=0, cnt=1. busy=1 with the macro, 0 without.
- Reset has priority over everything, including a mid-sweep or in-flight accept. The sweep restarts from cnt=1.
- Sweep timing:
  - The first edge with rst=1 drives wa3=1, we3=1.
  - The 31st edge drives wa3=31. busy falls in that same cycle, so readies may assert there.
  - Total sweep: 31 consecutive we3 cycles.
- Accept-to-write latency: a request accepted in cycle N appears on we3/wa3/wd3 in cycle N+1. The register file captures it at the end of N+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1...
- Simultaneous events: both requesters targeting the same address in one cycle are resolved by rr, and only one write issues. The loser is served the next cycle, and its later write wins.

## Configuration
- RF_INIT_SWEEP_EN defined: the INIT state, cnt and the sweep exist as described. busy resets to 1.
- RF_INIT_SWEEP_EN undefined: no INIT state and no counter. The block enters ARB directly from reset. busy is tied to 0. Register-file contents after reset are the register file's own responsibility.

## Test plan
- Reset with macro, release rst: we3=1 for 31 cycles, wa3=1..31, wd3=6 at wa3=5, 0x2004 at wa3=9, 0 elsewhere. busy falls with wa3=31.
- Without macro, release rst and assert req0 (addr=3, data=0xDEAD) in the first cycle: req0_ready=1 immediately. Next cycle we3=1, wa3=3, wd3=0xDEAD.
- Both requesters continuously valid for 6 cycles: grants 0,1,0,1,0,1, with each requester's data appearing on wd3 one cycle after its accept.
- req1 (addr=0, data=0x55) valid alone: req1_ready=1; next cycle we3=0, wa3/wd3 still load the request values, grant=1.
- rst driven low in the middle of the sweep (wa3=12) and released: restarts at wa3=1. During the restarted sweep, readies stay low despite req0 being valid.
- req0 held valid while req1 wins: req0 addr/data are held stable and req0 is accepted next cycle. Both writes to x7 issue in order, leaving wd3 with req0's data last.
